mips_instr_loader: RTL and testbench
====================================

// Module: mips_instr_loader
// PURPOSE
//  Encoder side of the MIPS control-decode path: accepts symbolic instructions (op enum + fields)
//  over a valid/ready stream, encodes each into a 32-bit MIPS word (opcode/funct exactly as decoded
//  by the single-cycle controller), buffers them in a small FIFO and writes them sequentially into
//  instruction memory. Used by testbenches/bootstrap to load programs before releasing the CPU.
// PARAMETERS
//  ADDR_W  10  instruction-memory byte-address width; addresses step by 4, wrap modulo 2^ADDR_W
//  DEPTH   4   encoded-word FIFO depth; power of two, >= 2
//  CNT_W   16  width of word_count
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle pulse: begin session (honoured only in IDLE)
//  base_addr   in   ADDR_W  first write address, sampled on start; low 2 bits ignored (forced 0)
//  finish      in   1       1-cycle pulse: no more input, drain FIFO (honoured only in RUN)
//  in_valid    in   1       instruction beat valid
//  in_ready    out  1       beat accepted when in_valid & in_ready
//  in_op       in   4       op_e: ADD,SUB,AND,OR,SLT,J,JAL,BEQ,BNE,ADDI,ANDI,LW,SW (0..12); 13-15 illegal
//  in_rs/in_rt/in_rd in 5   register fields
//  in_imm      in   16      I-type immediate / branch offset (raw, no shifting)
//  in_target   in   26      J-type word target
//  mem_we      out  1       write request; held with addr/data stable until mem_ready
//  mem_ready   in   1       memory accepts write this cycle
//  mem_addr    out  ADDR_W  byte address
//  mem_wdata   out  32      encoded instruction
//  busy        out  1       state != IDLE
//  done        out  1       1-cycle pulse, session complete
//  err         out  1       sticky: illegal op seen or address wrapped; cleared by start
//  word_count  out  CNT_W   words written this session (saturates at all-ones)
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty; in_ready, mem_we, done, err, busy = 0; mem_addr, mem_wdata,
//   word_count = 0. Reset mid-session discards all buffered and in-flight words.
//  FSM: IDLE -start-> RUN (addr<=base_addr&~3, count<=0, err<=0). RUN -finish-> DRAIN.
//   DRAIN -(FIFO empty & no pending write)-> DONE. DONE -> IDLE unconditionally, done=1 in DONE only.
//  in_ready = (state==RUN) & ~fifo_full. finish and an accepted beat in the same cycle: beat kept.
//  Encoding: R-type op=000000,shamt=0,funct ADD 100000/SUB 100010/AND 100100/OR 100101/SLT 101010;
//   J 000010|target; JAL 000011|target; BEQ 000100,BNE 000101,ADDI 001000,ANDI 001100,LW 100011,
//   SW 101011 as {op,rs,rt,imm}. Unused fields of the chosen format are ignored.
//  Illegal op: beat accepted (ready honoured), not enqueued, err<=1.
//  Latency: beat accepted in cycle N -> earliest mem_we in N+1. One write per cycle max.
//  mem_we = FIFO non-empty (RUN or DRAIN); on mem_we&mem_ready: pop, addr+=4, count+=1 (saturating).
//  Address wrap from 2^ADDR_W-4 to 0: write proceeds, err<=1.
//  FIFO full & in_valid: in_ready=0, beat stalls; simultaneous push/pop when full is not allowed
//   (ready already low); simultaneous push/pop otherwise keeps occupancy.
//  start outside IDLE and finish outside RUN ignored. mem_ready while mem_we=0 ignored.
// STRUCTURE
//  mips_isa_pkg: op_e enum, opcode/funct localparams, function encode_instr(op,rs,rt,rd,imm,target)
//   returning {valid,word}; shared with the controller's decoder tables.
//  One sub-module: sync_fifo #(W=32,DEPTH) (push/pop/full/empty, registered output).
//  Top: FSM, address/count registers, sticky err.
// TESTING
//  ADD rs=1 rt=2 rd=3, base 0x040 -> one write addr 0x040 data 0x00221820; done pulse; count=1.
//  LW rs=5 rt=4 imm=8 then J target=0x100 -> 0x8CA40008 @base, 0x08000100 @base+4, in order.
//  BEQ rs=1 rt=2 imm=0xFFFF with mem_ready low 3 cycles -> mem_we/addr/data 0x1022FFFF held stable.
//  Burst 6 beats, mem_ready=0 -> in_ready drops after 4 accepted; release -> all 6 written, no loss.
//  in_op=14 -> accepted, nothing written, err=1; next start clears err.
//  base=2^ADDR_W-4, 2 words -> second at addr 0, err=1; rst_n low mid-DRAIN -> all outputs zero.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
//   Symbolic MIPS instruction set shared by the instruction loader (encoder)
//   and the single-cycle controller's decoder tables.
//   Contents:
//     op_e         4-bit symbolic op (ADD..SW = 0..12; 13..15 are illegal)
//     OPC_* / FN_* primary opcode and R-type funct field values
//     enc_t        {valid, word} result of encoding
//     encode_instr op + fields -> 32-bit MIPS word, valid=0 for illegal ops
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_J    = 4'd5,
        OP_JAL  = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_ADDI = 4'd9,
        OP_ANDI = 4'd10,
        OP_LW   = 4'd11,
        OP_SW   = 4'd12
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic        valid;
        logic [31:0] word;
    } enc_t;

    // R-type: {op, rs, rt, rd, shamt=0, funct}; J-type: {op, target};
    // I-type: {op, rs, rt, imm}. Fields unused by a format are dropped.
    function automatic enc_t encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        enc_t r;
        r.valid = 1'b1;
        r.word  = 32'd0;
        case (op)
            OP_ADD:  r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            OP_SUB:  r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            OP_AND:  r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            OP_OR:   r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            OP_SLT:  r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            OP_J:    r.word = {OPC_J, target};
            OP_JAL:  r.word = {OPC_JAL, target};
            OP_BEQ:  r.word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:  r.word = {OPC_BNE, rs, rt, imm};
            OP_ADDI: r.word = {OPC_ADDI, rs, rt, imm};
            OP_ANDI: r.word = {OPC_ANDI, rs, rt, imm};
            OP_LW:   r.word = {OPC_LW, rs, rt, imm};
            OP_SW:   r.word = {OPC_SW, rs, rt, imm};
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered storage; the head entry is presented
//   on rdata whenever the FIFO is non-empty.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//     push, wdata  write an entry (ignored when full)
//     pop          remove the head entry (ignored when empty)
//     rdata        head entry
//     full, empty  occupancy flags
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_instr_loader.sv
// mips_instr_loader
//   Accepts symbolic MIPS instructions, encodes them to 32-bit words, buffers
//   them in a FIFO and writes them to sequential instruction-memory addresses.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start, base_addr     begin a session at base_addr (word aligned)
//     finish               stop accepting input and drain the FIFO
//     in_valid/in_ready    instruction beat handshake
//     in_op, in_rs, in_rt, in_rd, in_imm, in_target   instruction fields
//     mem_we/mem_ready     memory write handshake
//     mem_addr, mem_wdata  write address / encoded word
//     busy, done, err      status (done is a 1-cycle pulse, err is sticky)
//     word_count           words written this session (saturating)
//     fsm_state            current FSM state for observation
//
//   Handshakes: a transfer happens on the rising edge where valid and ready
//   are both high. in_ready never depends on in_valid. Once mem_we rises it
//   stays high with mem_addr/mem_wdata unchanged until the edge where
//   mem_ready is also high; mem_ready while mem_we is low has no effect.
module mips_instr_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  word_count,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Last word-aligned address; a write here wraps the address to 0.
    localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0]  state;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        accept;
    logic        push;
    logic        pop;
    enc_t        enc;

    assign enc      = encode_instr(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
    assign in_ready = (state == ST_RUN) & ~fifo_full;
    assign accept   = in_valid & in_ready;
    // Illegal ops complete the handshake but never reach the FIFO.
    assign push     = accept & enc.valid;
    assign mem_we   = ~fifo_empty & ((state == ST_RUN) | (state == ST_DRAIN));
    assign pop      = mem_we & mem_ready;

    // Data is gated so the bus reads zero while no write is requested.
    assign mem_wdata = mem_we ? fifo_rdata : 32'd0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    sync_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (enc.word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start)  state <= ST_RUN;
                ST_RUN:   if (finish) state <= ST_DRAIN;
                // pop empties the FIFO on this edge when it held one word,
                // so draining waits for the registered empty flag.
                ST_DRAIN: if (fifo_empty) state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                mem_addr   <= {base_addr[ADDR_W-1:2], 2'b00};
                word_count <= '0;
                err        <= 1'b0;
            end else begin
                if (pop) begin
                    mem_addr <= mem_addr + ADDR_W'(4);
                    if (word_count != {CNT_W{1'b1}}) begin
                        word_count <= word_count + 1'b1;
                    end
                end
                if ((accept && !enc.valid) || (pop && mem_addr == LAST_ADDR)) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_loader.sv
module tb_mips_instr_loader;

  localparam int ADDR_W = 10;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err;
  logic [15:0]       word_count;
  logic [1:0]        fsm_state;

  mips_instr_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .finish(finish), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  sess_base;
  int unsigned  sess_k;
  bit           err_exp;

  int unsigned opc_tab[13] = '{0, 0, 0, 0, 0, 2, 3, 4, 5, 8, 12, 35, 43};
  int unsigned fn_tab[5]   = '{32, 34, 36, 37, 42};

  function automatic logic [31:0] ref_word(int unsigned op, int unsigned rs,
      int unsigned rt, int unsigned rd, int unsigned imm, int unsigned tgt);
    int unsigned w;
    if (op < 5)
      w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + fn_tab[op];
    else if (op < 7)
      w = opc_tab[op] * (1 << 26) + tgt;
    else
      w = opc_tab[op] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    return w;
  endfunction

  function automatic void model_accept(int unsigned op, int unsigned rs,
      int unsigned rt, int unsigned rd, int unsigned imm, int unsigned tgt);
    int unsigned a;
    logic [ADDR_W-1:0] a10;
    if (op > 12) begin
      err_exp = 1'b1;
    end else begin
      a   = (sess_base + 4 * sess_k) % 1024;
      a10 = ADDR_W'(a);
      if (a == 1020) err_exp = 1'b1;
      exp_q.push_back({a10, ref_word(op, rs, rt, rd, imm, tgt)});
      sess_k++;
    end
  endfunction

  // ---------------- scoreboard (write monitor) ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_write: unexpected write addr=%h data=%h, none expected",
                 mem_addr, mem_wdata);
      end else begin
        if ({mem_addr, mem_wdata} !== exp_q[0]) begin
          n_err++;
          $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, exp_q[0][W-1:32], exp_q[0][31:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_session(input int unsigned base);
    base_addr = ADDR_W'(base);
    start     = 1'b1;
    sess_base = base & 32'h3FC;
    sess_k    = 0;
    err_exp   = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int unsigned op, input int unsigned rs,
      input int unsigned rt, input int unsigned rd, input int unsigned imm,
      input int unsigned tgt);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    in_target = 26'(tgt);
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        model_accept(op, rs, rt, rd, imm, tgt);
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_accept: in_ready never rose within 300 cycles (op=%0d)", op);
    end
  endtask

  task automatic finish_session(input string tag);
    bit seen = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_done: done not seen within 500 cycles", tag);
    end
    n_cmp++;
    if (word_count !== 16'(sess_k)) begin
      n_err++;
      $display("FAIL %s_count: got %0d expected %0d", tag, word_count, sess_k);
    end
    n_cmp++;
    if (err !== err_exp) begin
      n_err++;
      $display("FAIL %s_err: got %b expected %b", tag, err, err_exp);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d words still expected, 0 required", tag, exp_q.size());
      exp_q.delete();
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s_idle: done/busy=%b expected 00", tag, {done, busy});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 0; finish = 0; in_valid = 0; mem_ready = 0;
    base_addr = '0; in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_imm = 0; in_target = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, mem_we, done, err, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00000", {in_ready, mem_we, done, err, busy});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, word_count} !== '0) begin
      n_err++;
      $display("FAIL reset_values: addr=%h data=%h count=%0d expected all 0",
               mem_addr, mem_wdata, word_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    mem_ready = 1'b1;
    start_session(32'h040);
    send_beat(0, 1, 2, 3, 0, 0);
    n_cmp++;
    if (exp_q.size() != 1 || exp_q[0] !== {10'h040, 32'h00221820}) begin
      n_err++;
      $display("FAIL add_model: model entry wrong, expected addr 040 data 00221820");
    end
    finish_session("add");
  endtask

  task automatic test_lw_j();
    mem_ready = 1'b1;
    start_session(32'h080);
    send_beat(11, 5, 4, 0, 8, 0);
    send_beat(5, 0, 0, 0, 0, 32'h100);
    n_cmp++;
    if (ref_word(11, 5, 4, 0, 8, 0) !== 32'h8CA40008 ||
        ref_word(5, 0, 0, 0, 0, 32'h100) !== 32'h08000100) begin
      n_err++;
      $display("FAIL lw_j_model: reference encoding disagrees with known words");
    end
    finish_session("lw_j");
  endtask

  task automatic test_stall_hold();
    mem_ready = 1'b0;
    start_session(32'h200);
    send_beat(7, 1, 2, 0, 32'hFFFF, 0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'h200, 32'h1022FFFF}) begin
        n_err++;
        $display("FAIL stall_hold: cycle %0d we=%b addr=%h data=%h expected 1/200/1022ffff",
                 c, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1'b1;
    finish_session("stall");
  endtask

  task automatic test_burst();
    mem_ready = 1'b0;
    start_session(32'h300);
    for (int b = 0; b < 4; b++) send_beat(9, b, b + 1, 0, 16 * b, 0);
    in_valid = 1'b1;
    in_op    = 4'd3;
    repeat (2) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL burst_full: in_ready=%b expected 0 with 4 words buffered", in_ready);
      end
      tick();
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    send_beat(3, 7, 8, 9, 0, 0);
    send_beat(12, 10, 11, 0, 32'h1234, 0);
    finish_session("burst");
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1;
    start_session(32'h010);
    send_beat(14, 1, 2, 3, 4, 5);
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_err: err=%b expected 1", err);
    end
    finish_session("illegal");
    start_session(32'h010);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_clear: err=%b expected 0 after start", err);
    end
    finish_session("after_illegal");
  endtask

  task automatic test_wrap_and_reset();
    mem_ready = 1'b1;
    start_session(32'h3FC);
    send_beat(1, 3, 4, 5, 0, 0);
    send_beat(10, 6, 7, 0, 32'h00FF, 0);
    finish_session("wrap");
    // reset while draining a stalled FIFO
    mem_ready = 1'b0;
    start_session(32'h100);
    for (int b = 0; b < 3; b++) send_beat(2, b, b, b, 0, 0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL drain_state: busy=%b we=%b expected 1/1", busy, mem_we);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({in_ready, mem_we, done, err, busy, mem_addr, mem_wdata, word_count} !== '0) begin
      n_err++;
      $display("FAIL reset_drain: outputs not all zero (we=%b busy=%b addr=%h data=%h cnt=%0d)",
               mem_we, busy, mem_addr, mem_wdata, word_count);
    end
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({mem_we, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_discard: we/busy=%b expected 00", {mem_we, busy});
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      start_session($urandom_range(0, 1023));
      for (int b = 0, n = $urandom_range(1, 12); b < n; b++) begin
        send_beat(($urandom_range(0, 7) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF));
        repeat ($urandom_range(0, 2)) tick();
      end
      finish_session("random");
    end
    rand_ready = 1'b0;
    mem_ready  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_lw_j();
    test_stall_hold();
    test_burst();
    test_illegal();
    test_wrap_and_reset();
    test_random();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
